// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential fetch addresses to a registered instruction memory
// and feeds the IF/ID pipeline register, with a one-entry skid buffer to absorb stalls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instruction,
    output logic [31:0] PC_out,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_req_vld;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic        r_skid_vld;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;

    logic        w_issue;
    logic        w_unused_redirect_lsb;

    assign w_issue = !redirect && !stall;

    // Redirect targets are forced word-aligned, so the low bits are ignored.
    assign w_unused_redirect_lsb = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req_pc     <= 32'd0;
            r_req_vld    <= 1'b0;
            r_skid_instr <= 32'd0;
            r_skid_pc    <= 32'd0;
            r_skid_vld   <= 1'b0;
            r_ifid_instr <= 32'd0;
            r_ifid_pc    <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else if (redirect) begin
            // Flush wins over stall; the response arriving this cycle is dropped.
            r_pc         <= {redirect_pc[31:2], 2'b00};
            r_req_vld    <= 1'b0;
            r_skid_vld   <= 1'b0;
            r_ifid_valid <= 1'b0;
        end else if (stall) begin
            // Only one response can be in flight, so a single skid entry suffices.
            if (r_req_vld) begin
                r_skid_instr <= instruction;
                r_skid_pc    <= r_req_pc;
                r_skid_vld   <= 1'b1;
            end
            r_req_vld <= 1'b0;
        end else if (w_issue) begin
            r_req_vld <= 1'b1;
            r_req_pc  <= r_pc;
            r_pc      <= r_pc + 32'd4;
            if (r_skid_vld) begin
                r_ifid_instr <= r_skid_instr;
                r_ifid_pc    <= r_skid_pc;
                r_ifid_pc4   <= r_skid_pc + 32'd4;
                r_ifid_valid <= 1'b1;
                r_skid_vld   <= 1'b0;
            end else if (r_req_vld) begin
                r_ifid_instr <= instruction;
                r_ifid_pc    <= r_req_pc;
                r_ifid_pc4   <= r_req_pc + 32'd4;
                r_ifid_valid <= 1'b1;
            end else begin
                r_ifid_valid <= 1'b0;
            end
        end
    end

    assign PC_out     = r_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_pc4   = r_ifid_pc4;
    assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a registered instruction memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instruction;
    logic [31:0] PC_out;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    int checks;
    int failures;

    fetch_unit #(
        .RESET_PC(32'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instruction(instruction),
        .PC_out     (PC_out),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) instruction <= 32'hA000_0000 | PC_out;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        step();
        step();
        checks++;
        if (ifid_valid !== 1'b0 || ifid_pc !== 32'd0 || ifid_instr !== 32'd0 ||
            ifid_pc4 !== 32'd0) begin
            failures++;
            $display("FAIL reset_ifid got v=%b pc=%h ins=%h pc4=%h want all zero",
                     ifid_valid, ifid_pc, ifid_instr, ifid_pc4);
        end
        checks++;
        if (PC_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_pc got %h want 00000000", PC_out);
        end
    endtask

    task automatic test_sequence();
        rst = 1'b0;
        step();
        checks++;
        if (ifid_valid !== 1'b0 || PC_out !== 32'h4) begin
            failures++;
            $display("FAIL first_issue got v=%b PC_out=%h want v=0 PC_out=00000004",
                     ifid_valid, PC_out);
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(i * 4);
            step();
            checks++;
            if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc ||
                ifid_instr !== (32'hA000_0000 | exp_pc) || ifid_pc4 !== exp_pc + 32'd4) begin
                failures++;
                $display("FAIL seq_%0d got v=%b pc=%h ins=%h pc4=%h want v=1 pc=%h ins=%h pc4=%h",
                         i, ifid_valid, ifid_pc, ifid_instr, ifid_pc4, exp_pc,
                         32'hA000_0000 | exp_pc, exp_pc + 32'd4);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8 || PC_out !== 32'h10) begin
                failures++;
                $display("FAIL stall_hold_%0d got v=%b pc=%h PC_out=%h want v=1 pc=00000008 PC_out=00000010",
                         i, ifid_valid, ifid_pc, PC_out);
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h0C + 32'(i * 4);
            step();
            checks++;
            if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc ||
                ifid_instr !== (32'hA000_0000 | exp_pc) || ifid_pc4 !== exp_pc + 32'd4) begin
                failures++;
                $display("FAIL stall_release_%0d got v=%b pc=%h ins=%h pc4=%h want v=1 pc=%h",
                         i, ifid_valid, ifid_pc, ifid_instr, ifid_pc4, exp_pc);
            end
        end
    endtask

    task automatic test_redirect();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        checks++;
        if (ifid_valid !== 1'b0 || PC_out !== 32'h100) begin
            failures++;
            $display("FAIL redirect_edge got v=%b PC_out=%h want v=0 PC_out=00000100",
                     ifid_valid, PC_out);
        end
        step();
        checks++;
        if (ifid_valid !== 1'b0 || PC_out !== 32'h104) begin
            failures++;
            $display("FAIL redirect_bubble got v=%b PC_out=%h want v=0 PC_out=00000104",
                     ifid_valid, PC_out);
        end
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100 || ifid_instr !== 32'hA000_0100 ||
            ifid_pc4 !== 32'h104) begin
            failures++;
            $display("FAIL redirect_target got v=%b pc=%h ins=%h pc4=%h want v=1 pc=00000100 ins=a0000100 pc4=00000104",
                     ifid_valid, ifid_pc, ifid_instr, ifid_pc4);
        end
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h104 || ifid_instr !== 32'hA000_0104) begin
            failures++;
            $display("FAIL redirect_next got v=%b pc=%h ins=%h want v=1 pc=00000104 ins=a0000104",
                     ifid_valid, ifid_pc, ifid_instr);
        end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1;
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        checks++;
        if (ifid_valid !== 1'b0 || PC_out !== 32'h200) begin
            failures++;
            $display("FAIL flush_wins got v=%b PC_out=%h want v=0 PC_out=00000200",
                     ifid_valid, PC_out);
        end
        redirect = 1'b0;
        stall = 1'b0;
        step();
        checks++;
        if (ifid_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_skid_empty got v=%b pc=%h want v=0", ifid_valid, ifid_pc);
        end
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200 || ifid_instr !== 32'hA000_0200) begin
            failures++;
            $display("FAIL flush_target got v=%b pc=%h ins=%h want v=1 pc=00000200 ins=a0000200",
                     ifid_valid, ifid_pc, ifid_instr);
        end
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h204) begin
            failures++;
            $display("FAIL flush_next got v=%b pc=%h want v=1 pc=00000204", ifid_valid, ifid_pc);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        step();
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'hFFFF_FFF8 || ifid_pc4 !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_0 got v=%b pc=%h pc4=%h want v=1 pc=fffffff8 pc4=fffffffc",
                     ifid_valid, ifid_pc, ifid_pc4);
        end
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h0) begin
            failures++;
            $display("FAIL wrap_1 got v=%b pc=%h pc4=%h want v=1 pc=fffffffc pc4=00000000",
                     ifid_valid, ifid_pc, ifid_pc4);
        end
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_pc4 !== 32'h4 ||
            ifid_instr !== 32'hA000_0000) begin
            failures++;
            $display("FAIL wrap_2 got v=%b pc=%h pc4=%h ins=%h want v=1 pc=00000000 pc4=00000004 ins=a0000000",
                     ifid_valid, ifid_pc, ifid_pc4, ifid_instr);
        end
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        step();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (ifid_valid !== 1'b0 || ifid_pc !== 32'd0 || ifid_instr !== 32'd0 ||
            ifid_pc4 !== 32'd0 || PC_out !== 32'd0) begin
            failures++;
            $display("FAIL async_reset got v=%b pc=%h ins=%h pc4=%h PC_out=%h want all zero",
                     ifid_valid, ifid_pc, ifid_instr, ifid_pc4, PC_out);
        end
        step();
        rst = 1'b0;
        stall = 1'b0;
        step();
        checks++;
        if (ifid_valid !== 1'b0 || PC_out !== 32'h4) begin
            failures++;
            $display("FAIL restart_issue got v=%b PC_out=%h want v=0 PC_out=00000004",
                     ifid_valid, PC_out);
        end
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_instr !== 32'hA000_0000) begin
            failures++;
            $display("FAIL restart_first got v=%b pc=%h ins=%h want v=1 pc=00000000 ins=a0000000",
                     ifid_valid, ifid_pc, ifid_instr);
        end
        step();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin
            failures++;
            $display("FAIL restart_second got v=%b pc=%h want v=1 pc=00000004", ifid_valid, ifid_pc);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_redirect_over_stall();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
